// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential converter from four BCD digits to a binary value.
// Each accepted request folds one digit per clock into an accumulator
// (acc = acc*10 + digit), thousands digit first. A request with any digit
// above 9 is rejected on the accepting edge: it reports err and returns 0.
//
// Handshake: start is sampled only while busy is low (FSM in IDLE). The
// accepting edge captures the digits, so later changes on digit1..digit4
// are ignored. done pulses for exactly one cycle, with bin and err valid in
// that cycle. bin and err then hold until the next request updates them.
// busy is high from the accepting edge until done drops. All outputs are
// registered.
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int OUT_W  = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       digit1,
  input  logic [3:0]       digit2,
  input  logic [3:0]       digit3,
  input  logic [3:0]       digit4,
  output logic [OUT_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_o
);

  localparam int STEP_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DIGITS-1:0][3:0]  dig_q, dig_d;     // index 0 holds digit1
  logic [OUT_W-1:0]        acc_q, acc_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic [OUT_W-1:0]        bin_q, bin_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    bad_digit;
  logic                    last_step;
  logic [OUT_W-1:0]        acc_next;

  // A digit above 9 anywhere in the request makes it invalid.
  assign bad_digit = (digit1 > 4'd9) || (digit2 > 4'd9) ||
                     (digit3 > 4'd9) || (digit4 > 4'd9);

  assign last_step = (step_q == STEP_W'(DIGITS - 1));

  // acc*10 built from two shifts; width stays OUT_W, which holds 9999.
  assign acc_next = (acc_q << 3) + (acc_q << 1) +
                    {{(OUT_W-4){1'b0}}, dig_q[step_q]};

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    acc_d   = acc_q;
    step_d  = step_q;
    bin_d   = bin_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dig_d  = {digit4, digit3, digit2, digit1};
          acc_d  = '0;
          step_d = '0;
          err_d  = 1'b0;
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            state_d = CONV;
          end
        end
      end
      CONV: begin
        acc_d  = acc_next;
        step_d = step_q + STEP_W'(1);
        if (last_step) begin
          bin_d   = acc_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers; reset abandons any conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dig_q   <= '0;
      acc_q   <= '0;
      step_q  <= '0;
      bin_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bin     = bin_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign state_o = state_q;

endmodule
